mem_wb_stage: RTL and testbench

//  Writeback stage that sits directly upstream of the register file. Accepts one

---
 rtl/mem_wb_stage_if.sv | 31 +++
 rtl/mem_wb_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Writeback-stage bus: upstream instruction handshake, data-memory response and
// register-file write port, bundled for the mem_wb_stage boundary.
interface mem_wb_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_wen;
  logic [4:0]  in_rd_addr;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [2:0]  in_funct3;
  logic        flush;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        RegWEn;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        load_err;

  modport master (
    output in_valid, in_reg_wen, in_rd_addr, in_wb_sel, in_alu_result, in_pc_plus4,
           in_funct3, flush, dmem_rvalid, dmem_rdata,
    input  in_ready, RegWEn, rd_addr, rd_data, load_err
  );

  modport slave (
    input  in_valid, in_reg_wen, in_rd_addr, in_wb_sel, in_alu_result, in_pc_plus4,
           in_funct3, flush, dmem_rvalid, dmem_rdata,
    output in_ready, RegWEn, rd_addr, rd_data, load_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Writeback stage: selects ALU / load / PC+4 result, extends sub-word loads,
// waits (with optional timeout) for load data and drives the register-file write port.
module mem_wb_stage #(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst_n,
  mem_wb_stage_if.slave bus
);
  localparam int unsigned TimerW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              ld_wen_q, ld_wen_d;
  logic [4:0]        ld_rd_q, ld_rd_d;
  logic [2:0]        ld_f3_q, ld_f3_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic              pend_vld_q, pend_vld_d;
  logic [4:0]        pend_rd_q, pend_rd_d;
  logic [31:0]       pend_data_q, pend_data_d;
  logic              regwen_q, regwen_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              load_err_q, load_err_d;

  logic        accept, nl_wen, timeout_hit, ld_ok, wr_used;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data, nl_data;

  assign bus.in_ready = (state_q == StIdle) | ((state_q == StWait) & bus.dmem_rvalid);
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
  assign nl_wen       = bus.in_reg_wen & (bus.in_rd_addr != 5'd0);
  assign timeout_hit  = (LOAD_TIMEOUT != 0) && (timer_q == TimerW'(LOAD_TIMEOUT - 1));

  assign bus.RegWEn   = regwen_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.load_err = load_err_q;

  // Load extraction from the latched funct3 / byte offset.
  always_comb begin
    ld_byte = 8'd0;
    case (ld_off_q)
      2'd0:    ld_byte = bus.dmem_rdata[7:0];
      2'd1:    ld_byte = bus.dmem_rdata[15:8];
      2'd2:    ld_byte = bus.dmem_rdata[23:16];
      default: ld_byte = bus.dmem_rdata[31:24];
    endcase
    ld_half = ld_off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    ld_ok   = 1'b1;
    ld_data = 32'd0;
    case (ld_f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      3'b010:  ld_data = bus.dmem_rdata;
      default: ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    nl_data = 32'd0;
    case (bus.in_wb_sel)
      2'b00:   nl_data = bus.in_alu_result;
      2'b10:   nl_data = bus.in_pc_plus4;
      default: nl_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    ld_wen_d    = ld_wen_q;
    ld_rd_d     = ld_rd_q;
    ld_f3_d     = ld_f3_q;
    ld_off_d    = ld_off_q;
    pend_vld_d  = 1'b0;
    pend_rd_d   = pend_rd_q;
    pend_data_d = pend_data_q;
    regwen_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    load_err_d  = 1'b0;
    wr_used     = 1'b0;

    if (state_q == StWait) begin
      if (bus.flush) begin
        state_d = StIdle;
      end else if (bus.dmem_rvalid) begin
        state_d = StIdle;
        if (ld_wen_q && ld_ok) begin
          regwen_d  = 1'b1;
          rd_addr_d = ld_rd_q;
          rd_data_d = ld_data;
          wr_used   = 1'b1;
        end
      end else if (timeout_hit) begin
        state_d    = StIdle;
        load_err_d = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    // A parked write only exists in StIdle, so it never collides with a load write.
    if (pend_vld_q) begin
      regwen_d  = 1'b1;
      rd_addr_d = pend_rd_q;
      rd_data_d = pend_data_q;
      wr_used   = 1'b1;
    end

    if (accept) begin
      if (bus.in_wb_sel == 2'b01) begin
        state_d  = StWait;
        timer_d  = '0;
        ld_wen_d = nl_wen;
        ld_rd_d  = bus.in_rd_addr;
        ld_f3_d  = bus.in_funct3;
        ld_off_d = bus.in_alu_result[1:0];
      end else if (nl_wen) begin
        if (wr_used) begin
          // Write port busy this cycle: park the result one cycle to keep order.
          pend_vld_d  = 1'b1;
          pend_rd_d   = bus.in_rd_addr;
          pend_data_d = nl_data;
        end else begin
          regwen_d  = 1'b1;
          rd_addr_d = bus.in_rd_addr;
          rd_data_d = nl_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      ld_wen_q    <= 1'b0;
      ld_rd_q     <= 5'd0;
      ld_f3_q     <= 3'd0;
      ld_off_q    <= 2'd0;
      pend_vld_q  <= 1'b0;
      pend_rd_q   <= 5'd0;
      pend_data_q <= 32'd0;
      regwen_q    <= 1'b0;
      rd_addr_q   <= 5'd0;
      rd_data_q   <= 32'd0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ld_wen_q    <= ld_wen_d;
      ld_rd_q     <= ld_rd_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
      pend_vld_q  <= pend_vld_d;
      pend_rd_q   <= pend_rd_d;
      pend_data_q <= pend_data_d;
      regwen_q    <= regwen_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      load_err_q  <= load_err_d;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus pushes expected writes/errors, a
// negedge monitor pops and compares every RegWEn / load_err pulse.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_wb_stage_if bus ();

  mem_wb_stage #(.LOAD_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        is_err;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    e.is_err = 1'b0;
    e.addr   = addr;
    e.data   = data;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.addr   = 5'd0;
    e.data   = 32'd0;
    sb.push_back(e);
  endtask

  // Monitor: every output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (bus.RegWEn || bus.load_err)) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_event: RegWEn=%0b load_err=%0b rd_addr=%0d rd_data=%h, expected none",
                 bus.RegWEn, bus.load_err, bus.rd_addr, bus.rd_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_err) begin
          if (!(bus.load_err && !bus.RegWEn)) begin
            n_errors++;
            $display("FAIL load_err_event: RegWEn=%0b load_err=%0b, expected load_err only",
                     bus.RegWEn, bus.load_err);
          end
        end else if (!(bus.RegWEn && !bus.load_err && bus.rd_addr == e.addr &&
                       bus.rd_data == e.data)) begin
          n_errors++;
          $display("FAIL write_event: RegWEn=%0b load_err=%0b rd=%0d data=%h, expected rd=%0d data=%h",
                   bus.RegWEn, bus.load_err, bus.rd_addr, bus.rd_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic issue(input logic wen, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
    int n;
    n = 0;
    bus.in_valid      = 1'b1;
    bus.in_reg_wen    = wen;
    bus.in_rd_addr    = rd;
    bus.in_wb_sel     = sel;
    bus.in_alu_result = alu;
    bus.in_pc_plus4   = pc4;
    bus.in_funct3     = f3;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_ready_timeout: in_ready=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Issue a load, hold rvalid low for 'waits' cycles, then return 'rdata'.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input int waits, input logic [31:0] rdata,
                         input logic exp_wr, input logic [31:0] exp_data);
    issue(1'b1, rd, 2'b01, {30'h0000_0400, off}, 32'h0, f3);
    for (int i = 0; i < waits; i++) begin
      check("in_ready_wait", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    if (exp_wr) push_wr(rd, exp_data);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = rdata;
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_reg_wen    = 1'b0;
    bus.in_rd_addr    = 5'd0;
    bus.in_wb_sel     = 2'b00;
    bus.in_alu_result = 32'd0;
    bus.in_pc_plus4   = 32'd0;
    bus.in_funct3     = 3'd0;
    bus.flush         = 1'b0;
    bus.dmem_rvalid   = 1'b0;
    bus.dmem_rdata    = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_RegWEn", 32'(bus.RegWEn), 32'd0);
    check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_load_err", 32'(bus.load_err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU write: one-cycle pulse, values held afterwards.
    push_wr(5'd5, 32'h0000_1234);
    issue(1'b1, 5'd5, 2'b00, 32'h0000_1234, 32'h0, 3'd0);
    check("add_pulse", 32'(bus.RegWEn), 32'd1);
    @(posedge clk); #1;
    check("add_pulse_end", 32'(bus.RegWEn), 32'd0);
    check("add_hold_data", bus.rd_data, 32'h0000_1234);
    check("add_hold_addr", 32'(bus.rd_addr), 32'd5);

    // Loads.
    do_load(5'd7,  3'b000, 2'd3, 2, 32'h80FF_FF00, 1'b1, 32'hFFFF_FF80);
    do_load(5'd8,  3'b101, 2'd2, 1, 32'hBEEF_0000, 1'b1, 32'h0000_BEEF);
    do_load(5'd9,  3'b001, 2'd2, 0, 32'hBEEF_0000, 1'b1, 32'hFFFF_BEEF);
    do_load(5'd10, 3'b010, 2'd1, 1, 32'h1234_5678, 1'b1, 32'h1234_5678);
    do_load(5'd11, 3'b100, 2'd1, 0, 32'h0000_A500, 1'b1, 32'h0000_00A5);
    do_load(5'd21, 3'b001, 2'd3, 1, 32'h8001_1234, 1'b1, 32'hFFFF_8001);
    do_load(5'd12, 3'b011, 2'd0, 1, 32'h5555_5555, 1'b0, 32'h0);
    @(posedge clk); #1;
    check("unsupported_no_write", 32'(bus.RegWEn), 32'd0);

    // PC+4 / reserved selects, rd=0 and reg_wen=0 suppression.
    issue(1'b1, 5'd0, 2'b10, 32'h0, 32'h0000_0104, 3'd0);
    check("jal_rd0_no_write", 32'(bus.RegWEn), 32'd0);
    push_wr(5'd1, 32'h0000_0104);
    issue(1'b1, 5'd1, 2'b10, 32'h0, 32'h0000_0104, 3'd0);
    push_wr(5'd3, 32'h0000_0000);
    issue(1'b1, 5'd3, 2'b11, 32'h0000_0777, 32'h0000_0888, 3'd0);
    issue(1'b0, 5'd4, 2'b00, 32'h0000_0999, 32'h0, 3'd0);
    check("wen0_no_write", 32'(bus.RegWEn), 32'd0);

    // Timeout: load_err exactly 4 cycles after the accepting edge.
    push_err();
    issue(1'b1, 5'd13, 2'b01, 32'h0000_0400, 32'h0, 3'b010);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("timeout_early", 32'(bus.load_err), 32'd0);
    end
    @(posedge clk); #1;
    check("timeout_pulse", 32'(bus.load_err), 32'd1);
    check("timeout_no_write", 32'(bus.RegWEn), 32'd0);
    check("timeout_ready", 32'(bus.in_ready), 32'd1);

    // Flush wins over rvalid in WAIT.
    issue(1'b1, 5'd14, 2'b01, 32'h0000_0400, 32'h0, 3'b010);
    @(posedge clk); #1;
    bus.flush       = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.flush       = 1'b0;
    bus.dmem_rvalid = 1'b0;
    check("flush_rvalid_no_write", 32'(bus.RegWEn), 32'd0);
    check("flush_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back: accept while the load completes, then again next cycle.
    issue(1'b1, 5'd15, 2'b01, 32'h0000_0400, 32'h0, 3'b010);
    push_wr(5'd15, 32'hA5A5_0F0F);
    push_wr(5'd16, 32'h0000_0055);
    bus.dmem_rvalid   = 1'b1;
    bus.dmem_rdata    = 32'hA5A5_0F0F;
    bus.in_valid      = 1'b1;
    bus.in_reg_wen    = 1'b1;
    bus.in_rd_addr    = 5'd16;
    bus.in_wb_sel     = 2'b00;
    bus.in_alu_result = 32'h0000_0055;
    #1;
    check("b2b_ready_on_rvalid", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
    push_wr(5'd17, 32'h0000_0066);
    bus.in_rd_addr    = 5'd17;
    bus.in_alu_result = 32'h0000_0066;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Flush in IDLE blocks the accept.
    bus.in_valid      = 1'b1;
    bus.flush         = 1'b1;
    bus.in_reg_wen    = 1'b1;
    bus.in_rd_addr    = 5'd18;
    bus.in_wb_sel     = 2'b00;
    bus.in_alu_result = 32'h0000_0018;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("flush_idle_no_write", 32'(bus.RegWEn), 32'd0);

    // Reset while waiting for load data.
    issue(1'b1, 5'd19, 2'b01, 32'h0000_0400, 32'h0, 3'b010);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rstwait_RegWEn", 32'(bus.RegWEn), 32'd0);
    check("rstwait_rd_addr", 32'(bus.rd_addr), 32'd0);
    check("rstwait_rd_data", bus.rd_data, 32'd0);
    check("rstwait_load_err", 32'(bus.load_err), 32'd0);
    check("rstwait_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_wr(5'd20, 32'h0000_CAFE);
    issue(1'b1, 5'd20, 2'b00, 32'h0000_CAFE, 32'h0, 3'd0);
    repeat (6) @(posedge clk);
    #1;

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
